// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through read cache in front of sram_controller
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en_in,
  input  logic        r_en_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  output logic        sram_w_en_out,
  output logic        sram_r_en_out,
  output logic [31:0] sram_address_out,
  output logic [31:0] sram_write_data_out,
  input  logic [31:0] sram_read_data_in,
  input  logic        sram_ready_in
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);

  localparam int IW  = $clog2(SETS);
  localparam int PAD = 31 - IW - TAG_W;

  typedef enum logic [1:0] {IDLE, FILL_LO, FILL_HI, WRITE} state_t;

  state_t state_q, state_d;

  logic [1:0]       valid_q [SETS];
  logic             lru_q   [SETS];
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [63:0]      line_q  [2][SETS];
  logic [31:0]      line_buf_q;

  logic [IW-1:0]    idx;
  logic [TAG_W-1:0] tag;
  logic             word;
  logic             hit0, hit1, hit, hit_way, victim;
  logic [63:0]      hit_line;
  logic [31:0]      hit_word;
  logic             fill_we, wr_hit_we, lru_touch;

  assign idx  = address_in[IW:1];
  assign tag  = address_in[IW+TAG_W:IW+1];
  assign word = address_in[0];

  // Way0 wins if both ways somehow hold the same tag.
  assign hit0     = valid_q[idx][0] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[idx][1] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_line = line_q[hit_way][idx];
  assign hit_word = word ? hit_line[63:32] : hit_line[31:0];
  assign victim   = ~valid_q[idx][0] ? 1'b0 :
                    (~valid_q[idx][1] ? 1'b1 : lru_q[idx]);

  always_comb begin
    state_d             = state_q;
    ready_out           = 1'b0;
    read_data_out       = 32'd0;
    sram_r_en_out       = 1'b0;
    sram_w_en_out       = 1'b0;
    sram_address_out    = 32'd0;
    sram_write_data_out = 32'd0;
    fill_we             = 1'b0;
    wr_hit_we           = 1'b0;
    lru_touch           = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_en_in) begin
          state_d = WRITE;
        end else if (r_en_in) begin
          if (hit) begin
            ready_out     = 1'b1;
            read_data_out = hit_word;
            lru_touch     = 1'b1;
          end else begin
            state_d = FILL_LO;
          end
        end else begin
          ready_out = 1'b1;
        end
      end
      FILL_LO: begin
        sram_r_en_out    = 1'b1;
        sram_address_out = {{PAD{1'b0}}, tag, idx, 1'b0};
        if (sram_ready_in) state_d = FILL_HI;
      end
      FILL_HI: begin
        sram_r_en_out    = 1'b1;
        sram_address_out = {{PAD{1'b0}}, tag, idx, 1'b1};
        if (sram_ready_in) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        sram_w_en_out       = 1'b1;
        sram_address_out    = address_in;
        sram_write_data_out = write_data_in;
        if (sram_ready_in) begin
          ready_out = 1'b1;
          wr_hit_we = hit;
          lru_touch = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 2'b00;
        lru_q[i]   <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (fill_we) valid_q[idx][victim] <= 1'b1;
      if (lru_touch) lru_q[idx] <= ~hit_way;
    end
  end

  // Tags and data need no reset: they are only observed through valid bits.
  always_ff @(posedge clk) begin
    if (state_q == FILL_LO && sram_ready_in) line_buf_q <= sram_read_data_in;
    if (fill_we) begin
      tag_q[victim][idx]  <= tag;
      line_q[victim][idx] <= {sram_read_data_in, line_buf_q};
    end
    if (wr_hit_we) begin
      if (word) line_q[hit_way][idx][63:32] <= write_data_in;
      else      line_q[hit_way][idx][31:0]  <= write_data_in;
    end
  end

`ifdef CACHE_STATS_EN
  logic        just_filled_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The hit that completes a fill is not a fresh hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      just_filled_q <= 1'b0;
      hit_cnt_q     <= 32'd0;
      miss_cnt_q    <= 32'd0;
    end else begin
      just_filled_q <= fill_we;
      if (state_q == IDLE && lru_touch && !just_filled_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == IDLE && state_d == FILL_LO) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;
`endif

endmodule
